// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for mips_param_core:
//   - opcode_e : instruction opcodes (the 8-bit opcode field of an instruction)
//   - state_e  : controller states IDLE / FETCH / EXEC / HALT
//   - instr_t  : instruction word layout {opcode, dest, src1, src2}
//   - is_alu_op: true for opcodes handled by mips_alu
// -----------------------------------------------------------------------------
package mips_pkg;

   localparam int INSTR_W     = 32;
   localparam int FIELD_W     = 8;
   localparam int PROG_ADDR_W = 8;

   typedef enum logic [FIELD_W-1:0] {
      OP_NOOP = 8'h00,
      OP_LOAD = 8'h01,
      OP_LDNM = 8'h02,
      OP_STR  = 8'h03,
      OP_ADD  = 8'h04,
      OP_SUB  = 8'h05,
      OP_XOR  = 8'h06,
      OP_AND  = 8'h07,
      OP_JMP  = 8'h08,
      OP_JZ   = 8'h09,
      OP_PUSH = 8'h0A,
      OP_POP  = 8'h0B,
      OP_JNZ  = 8'h0C,
      OP_HALT = 8'h0F
   } opcode_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_HALT
   } state_e;

   typedef struct packed {
      logic [FIELD_W-1:0] opcode;
      logic [FIELD_W-1:0] dest;
      logic [FIELD_W-1:0] src1;
      logic [FIELD_W-1:0] src2;
   } instr_t;

   function automatic logic is_alu_op(input logic [FIELD_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) || (op == OP_AND);
   endfunction

endpackage

// File: rtl/mips_alu.sv
// -----------------------------------------------------------------------------
// mips_alu
// Combinational ALU for mips_param_core. Results wrap modulo 2^DATA_W.
// Ports:
//   i_op  in  8       opcode (ADD/SUB/XOR/AND; anything else yields 0)
//   i_a   in  DATA_W  first operand  (r[src1])
//   i_b   in  DATA_W  second operand (r[src2])
//   o_y   out DATA_W  result
// -----------------------------------------------------------------------------
module mips_alu
   import mips_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [FIELD_W-1:0] i_op,
   input  logic [DATA_W-1:0]  i_a,
   input  logic [DATA_W-1:0]  i_b,
   output logic [DATA_W-1:0]  o_y
);

   always_comb begin
      o_y = '0;
      case (i_op)
         OP_ADD:  o_y = i_a + i_b;
         OP_SUB:  o_y = i_a - i_b;
         OP_XOR:  o_y = i_a ^ i_b;
         OP_AND:  o_y = i_a & i_b;
         default: o_y = '0;
      endcase
   end

endmodule

// File: rtl/mips_param_core.sv
// -----------------------------------------------------------------------------
// mips_param_core
// Non-pipelined FETCH/EXEC processor with parametrised data width, register
// count, and instruction/data/stack depths. Memories are filled through the
// load port while the core is in IDLE or HALT; 'run' then starts execution
// from pc 0 with registers, sp and fault cleared.
//
// Optional feature: define MIPS_STACK_CHECK_EN to enable stack bounds checking
// (overflow/underflow sets 'fault' and halts on the offending instruction).
// Without it, sp wraps silently and 'fault' is tied low.
//
// Ports:
//   clk        in   1         clock, rising edge
//   rst        in   1         asynchronous active-high reset
//   run        in   1         start request, sampled in IDLE/HALT
//   prog_we    in   1         load-port write strobe (IDLE/HALT only)
//   prog_sel   in   1         0 = instruction memory, 1 = data memory
//   prog_addr  in   8         load address, truncated to the target depth
//   prog_data  in   max(32,DATA_W)  instruction word / data word (low DATA_W)
//   busy       out  1         high in FETCH/EXEC
//   halted     out  1         high in HALT
//   fault      out  1         latched stack fault
//   pc         out  clog2(IMEM_DEPTH)  program counter
//   ret_val    out  DATA_W    register NREGS-1
// -----------------------------------------------------------------------------
module mips_param_core
   import mips_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int NREGS       = 16,
   parameter int IMEM_DEPTH  = 32,
   parameter int DMEM_DEPTH  = 32,
   parameter int STACK_DEPTH = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  run,
   input  logic                                  prog_we,
   input  logic                                  prog_sel,
   input  logic [PROG_ADDR_W-1:0]                prog_addr,
   input  logic [(DATA_W > 32 ? DATA_W : 32)-1:0] prog_data,
   output logic                                  busy,
   output logic                                  halted,
   output logic                                  fault,
   output logic [$clog2(IMEM_DEPTH)-1:0]         pc,
   output logic [DATA_W-1:0]                     ret_val
);

   localparam int IA_W = $clog2(IMEM_DEPTH);
   localparam int DA_W = $clog2(DMEM_DEPTH);
   localparam int SA_W = $clog2(STACK_DEPTH);
   localparam int RA_W = $clog2(NREGS);
`ifdef MIPS_STACK_CHECK_EN
   // One extra bit so sp can represent a completely full stack.
   localparam int SP_W = SA_W + 1;
`else
   localparam int SP_W = SA_W;
`endif

   state_e              r_state, w_state_n;
   instr_t              r_ir;
   logic [IA_W-1:0]     r_pc;
   logic [SP_W-1:0]     r_sp;
   logic [INSTR_W-1:0]  r_imem [IMEM_DEPTH];
   logic [DATA_W-1:0]   r_dmem [DMEM_DEPTH];
   logic [DATA_W-1:0]   r_stk  [STACK_DEPTH];
   logic [DATA_W-1:0]   r_regs [NREGS];

   logic                w_load_ok, w_start, w_stop;
   logic [DATA_W-1:0]   w_src1_val, w_src2_val, w_alu_y, w_dmem_rd, w_stk_rd;
   logic                w_push_full, w_pop_empty;
   logic                w_rf_we, w_dmem_we, w_stk_we, w_sp_inc, w_sp_dec, w_jump, w_stk_fault;
   logic [DATA_W-1:0]   w_rf_wdata;
   logic                w_unused_addr;

   assign w_load_ok = (r_state == S_IDLE) || (r_state == S_HALT);
   assign w_start   = w_load_ok && run;

   // Out-of-range register indices read as zero.
   assign w_src1_val = (32'(r_ir.src1) < NREGS) ? r_regs[r_ir.src1[RA_W-1:0]] : '0;
   assign w_src2_val = (32'(r_ir.src2) < NREGS) ? r_regs[r_ir.src2[RA_W-1:0]] : '0;
   assign w_dmem_rd  = r_dmem[DA_W'(r_ir.src2)];
   assign w_stk_rd   = r_stk[SA_W'(r_sp - 1'b1)];
   // Only the low bits of the load address reach the memories.
   assign w_unused_addr = ^prog_addr;

   mips_alu #(.DATA_W(DATA_W)) u_alu (
      .i_op (r_ir.opcode),
      .i_a  (w_src1_val),
      .i_b  (w_src2_val),
      .o_y  (w_alu_y)
   );

`ifdef MIPS_STACK_CHECK_EN
   assign w_push_full = (r_sp == SP_W'(STACK_DEPTH));
   assign w_pop_empty = (r_sp == '0);
`else
   assign w_push_full = 1'b0;
   assign w_pop_empty = 1'b0;
`endif

   // Instruction decode: all side effects of the instruction held in r_ir.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      w_rf_we     = 1'b0;
      w_rf_wdata  = '0;
      w_dmem_we   = 1'b0;
      w_stk_we    = 1'b0;
      w_sp_inc    = 1'b0;
      w_sp_dec    = 1'b0;
      w_jump      = 1'b0;
      w_stk_fault = 1'b0;
      if (r_state == S_EXEC) begin
         case (r_ir.opcode)
            OP_LOAD: begin w_rf_we = 1'b1; w_rf_wdata = w_dmem_rd; end
            OP_LDNM: begin w_rf_we = 1'b1; w_rf_wdata = DATA_W'(r_ir.src2); end
            OP_STR:  w_dmem_we = 1'b1;
            OP_JMP:  w_jump = 1'b1;
            OP_JZ:   w_jump = (w_src2_val == '0);
            OP_JNZ:  w_jump = (w_src2_val != '0);
            OP_PUSH: begin
               if (w_push_full) w_stk_fault = 1'b1;
               else begin w_stk_we = 1'b1; w_sp_inc = 1'b1; end
            end
            OP_POP: begin
               if (w_pop_empty) w_stk_fault = 1'b1;
               else begin w_rf_we = 1'b1; w_rf_wdata = w_stk_rd; w_sp_dec = 1'b1; end
            end
            default: begin
               if (is_alu_op(r_ir.opcode)) begin
                  w_rf_we    = 1'b1;
                  w_rf_wdata = w_alu_y;
               end
            end
         endcase
         // Writes to nonexistent registers are dropped.
         if (32'(r_ir.dest) >= NREGS) w_rf_we = 1'b0;
      end
   end

   assign w_stop = (r_ir.opcode == OP_HALT) || w_stk_fault;

   always_comb begin
      w_state_n = r_state;
      case (r_state)
         S_IDLE, S_HALT: if (run) w_state_n = S_FETCH;
         S_FETCH:        w_state_n = S_EXEC;
         S_EXEC:         w_state_n = w_stop ? S_HALT : S_FETCH;
         default:        w_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= '0;
         r_sp <= '0;
         r_ir <= '0;
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (w_start) begin
         r_pc <= '0;
         r_sp <= '0;
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else if (r_state == S_FETCH) begin
         r_ir <= r_imem[r_pc];
      end else if (r_state == S_EXEC) begin
         if (w_rf_we)       r_regs[r_ir.dest[RA_W-1:0]] <= w_rf_wdata;
         if (w_sp_inc)      r_sp <= r_sp + 1'b1;
         else if (w_sp_dec) r_sp <= r_sp - 1'b1;
         // HALT and faulting instructions leave pc on themselves.
         if (!w_stop)       r_pc <= w_jump ? IA_W'(r_ir.dest) : r_pc + 1'b1;
      end
   end

   // NOTE: memories have no reset; their contents survive rst and are defined only by writes.
   always_ff @(posedge clk) begin
      if (prog_we && w_load_ok) begin
         if (prog_sel) r_dmem[DA_W'(prog_addr)] <= prog_data[DATA_W-1:0];
         else          r_imem[IA_W'(prog_addr)] <= prog_data[INSTR_W-1:0];
      end
      if (w_dmem_we) r_dmem[DA_W'(r_ir.dest)] <= w_src2_val;
      if (w_stk_we)  r_stk[SA_W'(r_sp)]       <= w_src2_val;
   end

`ifdef MIPS_STACK_CHECK_EN
   logic r_fault;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                     r_fault <= 1'b0;
      else if (w_start)                            r_fault <= 1'b0;
      else if (r_state == S_EXEC && w_stk_fault)   r_fault <= 1'b1;
   end
   assign fault = r_fault;
`else
   assign fault = 1'b0;
`endif

   assign busy    = (r_state == S_FETCH) || (r_state == S_EXEC);
   assign halted  = (r_state == S_HALT);
   assign pc      = r_pc;
   assign ret_val = r_regs[NREGS-1];

endmodule

// File: tb/tb_mips_param_core.sv
// -----------------------------------------------------------------------------
// tb_mips_param_core
// Directed bench for mips_param_core (default parameters). Each program run
// pushes its expected result onto a scoreboard; the entry is popped and
// compared once the core reports HALT.
// -----------------------------------------------------------------------------
module tb_mips_param_core;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst, run, prog_we, prog_sel;
   logic [7:0]  prog_addr;
   logic [31:0] prog_data;
   logic        busy, halted, fault;
   logic [4:0]  pc;
   logic [31:0] ret_val;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] ret;
      logic [4:0]  pc;
      logic        fault;
      int          cycles;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] prog[$];

   always #5 clk = ~clk;

   mips_param_core #(
      .DATA_W(32), .NREGS(16), .IMEM_DEPTH(32), .DMEM_DEPTH(32), .STACK_DEPTH(16)
   ) dut (
      .clk(clk), .rst(rst), .run(run),
      .prog_we(prog_we), .prog_sel(prog_sel), .prog_addr(prog_addr), .prog_data(prog_data),
      .busy(busy), .halted(halted), .fault(fault), .pc(pc), .ret_val(ret_val)
   );

   function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] d,
                                       input logic [7:0] s1, input logic [7:0] s2);
      return {op, d, s1, s2};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_prog();
      foreach (prog[i]) begin
         @(negedge clk);
         prog_we = 1'b1; prog_sel = 1'b0; prog_addr = 8'(i); prog_data = prog[i];
      end
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic load_data(input logic [7:0] addr, input logic [31:0] val);
      @(negedge clk);
      prog_we = 1'b1; prog_sel = 1'b1; prog_addr = addr; prog_data = val;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   // Pulses run (optionally with a simultaneous imem[0] write), waits for HALT
   // and compares against the scoreboard entry pushed at launch.
   task automatic run_prog(input string tag, input logic [31:0] ret_e, input logic [4:0] pc_e,
                           input logic fault_e, input int cyc_e,
                           input bit sim_wr, input logic [31:0] sim_word);
      exp_t e;
      int   n;
      e.tag = tag; e.ret = ret_e; e.pc = pc_e; e.fault = fault_e; e.cycles = cyc_e;
      sb.push_back(e);
      @(negedge clk);
      run = 1'b1;
      if (sim_wr) begin
         prog_we = 1'b1; prog_sel = 1'b0; prog_addr = 8'd0; prog_data = sim_word;
      end
      @(negedge clk);
      run = 1'b0; prog_we = 1'b0;
      n = 0;
      while (halted !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      e = sb.pop_front();
      check({e.tag, "_halted"}, 32'(halted), 32'd1);
      check({e.tag, "_cycles"}, 32'(n), 32'(e.cycles));
      check({e.tag, "_busy"},   32'(busy), 32'd0);
      check({e.tag, "_ret"},    ret_val, e.ret);
      check({e.tag, "_pc"},     32'(pc), 32'(e.pc));
      check({e.tag, "_fault"},  32'(fault), 32'(e.fault));
   endtask

   initial begin
      int n;
      rst = 1'b1; run = 1'b0; prog_we = 1'b0; prog_sel = 1'b0; prog_addr = '0; prog_data = '0;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_ret", ret_val, 32'd0);

      // 5 - 3
      prog = '{ins(OP_LDNM,1,0,5), ins(OP_LDNM,2,0,3), ins(OP_SUB,15,1,2), ins(OP_HALT,0,0,0)};
      load_prog();
      run_prog("sub_5_3", 32'd2, 5'd3, 1'b0, 8, 1'b0, '0);

      // 0 - 1 wraps
      prog = '{ins(OP_LDNM,1,0,0), ins(OP_LDNM,2,0,1), ins(OP_SUB,15,1,2), ins(OP_HALT,0,0,0)};
      load_prog();
      run_prog("sub_wrap", 32'hFFFF_FFFF, 5'd3, 1'b0, 8, 1'b0, '0);

      // r20 does not exist: write dropped, read returns 0 (no aliasing onto r4)
      prog = '{ins(OP_LDNM,4,0,6), ins(OP_LDNM,20,0,9), ins(OP_ADD,15,4,20), ins(OP_HALT,0,0,0)};
      load_prog();
      run_prog("reg_oob", 32'd6, 5'd3, 1'b0, 8, 1'b0, '0);

      // XOR/AND/ADD, unknown opcode, taken JZ and JNZ skipping dead code
      prog = '{ins(OP_LDNM,1,0,8'h5C), ins(OP_LDNM,2,0,8'h3A), ins(OP_XOR,3,1,2),
               ins(OP_AND,4,1,2), ins(OP_ADD,15,3,4), ins(8'h0D,15,0,0),
               ins(OP_JZ,8,0,0), ins(OP_LDNM,15,0,0), ins(OP_JNZ,10,0,1),
               ins(OP_LDNM,15,0,0), ins(OP_HALT,0,0,0)};
      load_prog();
      run_prog("alu_jumps", 32'h7E, 5'd10, 1'b0, 18, 1'b0, '0);

      // Stack LIFO and STR
      prog = '{ins(OP_LDNM,1,0,7), ins(OP_LDNM,2,0,9), ins(OP_PUSH,0,0,1), ins(OP_PUSH,0,0,2),
               ins(OP_POP,15,0,0), ins(OP_STR,1,0,15), ins(OP_POP,15,0,0), ins(OP_HALT,0,0,0)};
      load_prog();
      run_prog("stack", 32'd7, 5'd7, 1'b0, 16, 1'b0, '0);

      // dmem[1] written by STR, dmem[5] by the load port
      load_data(8'd5, 32'h1234);
      prog = '{ins(OP_LOAD,15,0,1), ins(OP_LOAD,3,0,5), ins(OP_ADD,15,15,3), ins(OP_HALT,0,0,0)};
      load_prog();
      run_prog("dmem_read", 32'h123D, 5'd3, 1'b0, 8, 1'b0, '0);

      // Load-port write coinciding with run must be seen by the first FETCH
      prog = '{ins(OP_LDNM,15,0,8'h11), ins(OP_HALT,0,0,0)};
      load_prog();
      run_prog("wr_with_run", 32'h77, 5'd1, 1'b0, 4, 1'b1, ins(OP_LDNM,15,0,8'h77));

      // Countdown: three loop iterations
      prog = '{ins(OP_LDNM,15,0,3), ins(OP_LDNM,2,0,1), ins(OP_SUB,15,15,2),
               ins(OP_JNZ,2,0,15), ins(OP_HALT,0,0,0)};
      load_prog();
      run_prog("countdown", 32'd0, 5'd4, 1'b0, 18, 1'b0, '0);

      // Countdown again, with a blocked load-port write, then reset in iteration 2
      load_data(8'd7, 32'h55);
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      n = 0;
      while (n < 9) begin
         @(negedge clk);
         n++;
         prog_we = 1'b0;
         if (n == 3) begin
            prog_we = 1'b1; prog_sel = 1'b1; prog_addr = 8'd7; prog_data = 32'hBAD;
         end
      end
      check("mid_run_busy", 32'(busy), 32'd1);
      check("mid_run_ret", ret_val, 32'd2);
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_halted", 32'(halted), 32'd0);
      check("abort_pc", 32'(pc), 32'd0);
      check("abort_ret", ret_val, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      prog = '{ins(OP_LOAD,15,0,7), ins(OP_HALT,0,0,0)};
      load_prog();
      run_prog("ld_blocked", 32'h55, 5'd1, 1'b0, 4, 1'b0, '0);

`ifdef MIPS_STACK_CHECK_EN
      // POP on empty stack faults and halts on the POP
      prog = '{ins(OP_POP,15,0,0), ins(OP_HALT,0,0,0)};
      load_prog();
      run_prog("pop_empty", 32'd0, 5'd0, 1'b1, 2, 1'b0, '0);
`else
      // Fill all 16 stack words, sp wraps to 0, POP then reads stk[15] and execution continues
      prog = '{ins(OP_LDNM,1,0,8'h2A), ins(OP_LDNM,2,0,1), ins(OP_LDNM,3,0,16),
               ins(OP_PUSH,0,0,1), ins(OP_SUB,3,3,2), ins(OP_JNZ,3,0,3),
               ins(OP_POP,15,0,0), ins(OP_LDNM,14,0,1), ins(OP_ADD,15,15,14), ins(OP_HALT,0,0,0)};
      load_prog();
      run_prog("pop_empty", 32'h2B, 5'd9, 1'b0, 110, 1'b0, '0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
